// File: rtl/imm_arith_encoder.sv
// ---------------------------------------------------------------------------
// imm_arith_encoder
//
// Encodes RISC-V OP-IMM arithmetic/logic/shift instructions from a request
// record (kind, rd, rs1, imm) and queues the 32-bit words in a 2-entry FIFO
// with valid/ready handshakes on both sides.
//
// Build option:
//   IMM_ARITH_ENCODER_RV64_EN  - when defined, shifts use a 6-bit shamt
//                                (RV64 form); otherwise a 5-bit shamt (RV32).
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   request present
//   in_ready   out  1   FIFO has space (occupancy < 2), registered-state only
//   in_kind    in   imm_arith_kind_t  operation to encode
//   in_rd      in   5   destination register
//   in_rs1     in   5   source register
//   in_imm     in   12  immediate / shift amount in low bits
//   out_valid  out  1   head entry present
//   out_ready  in   1   consumer takes head entry
//   out_insn   out  32  encoded word (0 when an error or when empty)
//   out_err    out  1   head request could not be encoded
// ---------------------------------------------------------------------------

package opcode_type;
  typedef enum logic [3:0] {
    iak_addi    = 4'd0,
    iak_slti    = 4'd1,
    iak_sltiu   = 4'd2,
    iak_xori    = 4'd3,
    iak_ori     = 4'd4,
    iak_andi    = 4'd5,
    iak_slli    = 4'd6,
    iak_srli    = 4'd7,
    iak_srai    = 4'd8,
    iak_invalid = 4'd15
  } imm_arith_kind_t;
endpackage

module imm_arith_encoder
  import opcode_type::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  imm_arith_kind_t in_kind,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [11:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_insn,
  output logic            out_err
);

`ifdef IMM_ARITH_ENCODER_RV64_EN
  localparam int SHAMT_W = 6;
`else
  localparam int SHAMT_W = 5;
`endif

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // -------------------------------------------------------------------------
  // Combinational encoder
  // -------------------------------------------------------------------------
  logic [2:0]  w_funct3;
  logic        w_is_shift;
  logic        w_arith;      // selects srai (bit 30 of the word)
  logic        w_kind_bad;
  logic        w_shamt_bad;
  logic        w_err;
  logic [11:0] w_imm_field;
  logic [31:0] w_insn;

  always_comb begin
    w_funct3   = 3'b000;
    w_is_shift = 1'b0;
    w_arith    = 1'b0;
    w_kind_bad = 1'b0;
    case (in_kind)
      iak_addi:  w_funct3 = 3'b000;
      iak_slti:  w_funct3 = 3'b010;
      iak_sltiu: w_funct3 = 3'b011;
      iak_xori:  w_funct3 = 3'b100;
      iak_ori:   w_funct3 = 3'b110;
      iak_andi:  w_funct3 = 3'b111;
      iak_slli: begin
        w_funct3   = 3'b001;
        w_is_shift = 1'b1;
      end
      iak_srli: begin
        w_funct3   = 3'b101;
        w_is_shift = 1'b1;
      end
      iak_srai: begin
        w_funct3   = 3'b101;
        w_is_shift = 1'b1;
        w_arith    = 1'b1;
      end
      // iak_invalid and any unassigned encoding
      default:   w_kind_bad = 1'b1;
    endcase
  end

  // Any immediate bit above the shamt field makes a shift unencodable.
  assign w_shamt_bad = w_is_shift && (|in_imm[11:SHAMT_W]);
  assign w_err       = w_kind_bad || w_shamt_bad;

  // Shift form: {0, arith, zeros, shamt}; the upper field width shrinks by
  // one bit in the 6-bit shamt build, so bit 30 stays the srai selector.
  assign w_imm_field = w_is_shift
                     ? {1'b0, w_arith, {(10 - SHAMT_W){1'b0}}, in_imm[SHAMT_W-1:0]}
                     : in_imm;

  assign w_insn = w_err ? 32'h0
                        : {w_imm_field, in_rs1, w_funct3, in_rd, OPC_OP_IMM};

  // -------------------------------------------------------------------------
  // 2-entry FIFO
  // -------------------------------------------------------------------------
  logic [32:0] r_mem [2];    // {err, insn}
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;
  logic [32:0] w_head;

  assign in_ready  = ~r_count[1];          // occupancy < 2
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Storage carries no reset; outputs are gated by out_valid instead, so a
  // stale entry can never be observed after reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst && w_push && (r_wr_ptr == 1'(gi))) begin
        r_mem[gi] <= {w_err, w_insn};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;   // none, or push+pop at occupancy 1
      endcase
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign out_insn = out_valid ? w_head[31:0] : 32'h0;
  assign out_err  = out_valid ? w_head[32]   : 1'b0;

endmodule

// File: tb/tb_imm_arith_encoder.sv
module tb_imm_arith_encoder;
  import opcode_type::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  imm_arith_kind_t in_kind;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [11:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_insn;
  logic            out_err;

  imm_arith_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: OP-IMM word built from field arithmetic.
  function automatic void ref_enc(input imm_arith_kind_t k, input int rd, input int rs1,
                                  input int imm, output logic [31:0] insn, output logic err);
    int  f3;
    bit  shift;
    bit  bad;
    int  max_sh;
`ifdef IMM_ARITH_ENCODER_RV64_EN
    max_sh = 63;
`else
    max_sh = 31;
`endif
    f3 = 0; shift = 0; bad = 0;
    case (k)
      iak_addi:  f3 = 0;
      iak_slti:  f3 = 2;
      iak_sltiu: f3 = 3;
      iak_xori:  f3 = 4;
      iak_ori:   f3 = 6;
      iak_andi:  f3 = 7;
      iak_slli:  begin f3 = 1; shift = 1; end
      iak_srli:  begin f3 = 5; shift = 1; end
      iak_srai:  begin f3 = 5; shift = 1; end
      default:   bad = 1;
    endcase
    if (shift && imm > max_sh) bad = 1;
    err  = bad;
    insn = 32'h0;
    if (!bad) begin
      insn = 32'(imm) * 32'h100000 + 32'(rs1) * 32'h8000 + 32'(f3) * 32'h1000
           + 32'(rd) * 32'h80 + 32'h13;
      if (k == iak_srai) insn = insn + 32'h4000_0000;
    end
  endfunction

  typedef struct {
    imm_arith_kind_t kind;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [11:0]     imm;
    logic [31:0]     exp_insn;
    logic            exp_err;
  } vec_t;

  vec_t vecs [13];

  logic [31:0] q_insn [$];
  logic        q_err  [$];

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_kind   = iak_addi;
    in_rd     = 5'd0;
    in_rs1    = 5'd0;
    in_imm    = 12'd0;
    out_ready = 1'b0;
  endtask

  task automatic drive_req(input imm_arith_kind_t k, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [11:0] imm);
    in_valid = 1'b1;
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_imm   = imm;
  endtask

  initial begin
    logic [31:0] e_insn;
    logic        e_err;
    logic [31:0] held;
    int          acc_cycles;

    vecs[0]  = '{iak_addi,  5'd1,  5'd2,  12'h005, 32'h00510093, 1'b0};
    vecs[1]  = '{iak_slti,  5'd5,  5'd6,  12'hFFF, 32'hFFF32293, 1'b0};
    vecs[2]  = '{iak_sltiu, 5'd7,  5'd8,  12'h800, 32'h80043393, 1'b0};
    vecs[3]  = '{iak_xori,  5'd31, 5'd31, 12'h123, 32'h123FCF93, 1'b0};
    vecs[4]  = '{iak_ori,   5'd0,  5'd0,  12'h7FF, 32'h7FF06013, 1'b0};
    vecs[5]  = '{iak_andi,  5'd10, 5'd11, 12'h0AA, 32'h0AA5F513, 1'b0};
    vecs[6]  = '{iak_srai,  5'd3,  5'd4,  12'h007, 32'h40725193, 1'b0};
    vecs[7]  = '{iak_srli,  5'd2,  5'd3,  12'h01F, 32'h01F1D113, 1'b0};
    vecs[8]  = '{iak_srli,  5'd2,  5'd3,  12'h800, 32'h00000000, 1'b1};
    vecs[9]  = '{iak_invalid, 5'd1, 5'd2, 12'h005, 32'h00000000, 1'b1};
    vecs[10] = '{iak_srai,  5'd1,  5'd1,  12'h400, 32'h00000000, 1'b1};
`ifdef IMM_ARITH_ENCODER_RV64_EN
    vecs[11] = '{iak_slli,  5'd1,  5'd1,  12'h020, 32'h02009093, 1'b0};
    vecs[12] = '{iak_slli,  5'd4,  5'd5,  12'h03F, 32'h03F29213, 1'b0};
`else
    vecs[11] = '{iak_slli,  5'd1,  5'd1,  12'h020, 32'h00000000, 1'b1};
    vecs[12] = '{iak_slli,  5'd4,  5'd5,  12'h03F, 32'h00000000, 1'b1};
`endif

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_insn",  out_insn,       32'h0);
    check("reset out_err",   32'(out_err),   32'd0);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 13; i++) begin
      drive_req(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].imm);
      out_ready = 1'b1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_insn", i),  out_insn, vecs[i].exp_insn);
      check($sformatf("vec%0d out_err", i),   32'(out_err), 32'(vecs[i].exp_err));
      $display("vec%0d kind=%0d insn=0x%08h err=%0b", i, vecs[i].kind, out_insn, out_err);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
    end

    // ---------------- stall with three back-to-back requests ----------------
    out_ready = 1'b0;
    drive_req(iak_addi, 5'd1, 5'd2, 12'h005);               // A = 00510093
    check("stall A in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drive_req(iak_srai, 5'd3, 5'd4, 12'h007);               // B = 40725193
    check("stall B in_ready", 32'(in_ready), 32'd1);
    check("stall head A", out_insn, 32'h00510093);
    @(posedge clk); @(negedge clk);
    drive_req(iak_xori, 5'd31, 5'd31, 12'h123);             // C = 123FCF93
    check("stall C in_ready", 32'(in_ready), 32'd0);
    held = out_insn;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      check("stall hold insn", out_insn, 32'h00510093);
      check("stall hold ready", 32'(in_ready), 32'd0);
    end
    check("stall held equal", held, 32'h00510093);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);                         // A popped
    check("drain head B", out_insn, 32'h40725193);
    check("drain C ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);                         // push C, pop B
    in_valid = 1'b0;
    check("drain head C", out_insn, 32'h123FCF93);
    check("drain C valid", 32'(out_valid), 32'd1);
    @(posedge clk); @(negedge clk);
    check("drain empty", 32'(out_valid), 32'd0);
    $display("stall sequence A,B,C drained");

    // ---------------- reset while full ----------------
    out_ready = 1'b0;
    drive_req(iak_ori, 5'd9, 5'd9, 12'h111);
    acc_cycles = 0;
    while (in_ready && acc_cycles < 10) begin
      @(posedge clk); @(negedge clk);
      acc_cycles++;
    end
    check("full before reset", 32'(in_ready), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;                                       // ignored under reset
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst-full out_valid", 32'(out_valid), 32'd0);
    check("rst-full in_ready",  32'(in_ready),  32'd1);
    check("rst-full out_insn",  out_insn,       32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      check("rst-full stays empty", 32'(out_valid), 32'd0);
    end
    $display("reset with occupancy 2 discarded entries");

    // ---------------- randomized traffic vs queue model ----------------
    q_insn.delete();
    q_err.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit              push;
      bit              pop;
      imm_arith_kind_t k;
      int              sel;
      // compare current outputs with the model
      check("rnd out_valid", 32'(out_valid), 32'(q_insn.size() > 0));
      check("rnd in_ready",  32'(in_ready),  32'(q_insn.size() < 2));
      if (q_insn.size() > 0) begin
        check("rnd out_insn", out_insn, q_insn[0]);
        check("rnd out_err",  32'(out_err), 32'(q_err[0]));
      end
      // new stimulus
      sel = $urandom_range(0, 10);
      k = (sel == 10) ? iak_invalid : imm_arith_kind_t'(4'(sel > 8 ? 8 : sel));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kind   = k;
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_imm    = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 70)) : 12'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      if (rst) begin
        q_insn.delete();
        q_err.delete();
      end else begin
        push = in_valid && (q_insn.size() < 2);
        pop  = out_ready && (q_insn.size() > 0);
        ref_enc(k, int'(in_rd), int'(in_rs1), int'(in_imm), e_insn, e_err);
        if (pop) begin
          void'(q_insn.pop_front());
          void'(q_err.pop_front());
        end
        if (push) begin
          q_insn.push_back(e_insn);
          q_err.push_back(e_err);
        end
      end
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
